// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select encodings, default mult/div latencies, busy counter width.
package pipe_ctrl_pkg;

    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_e;

    // A producing stage matches a reader when it writes the same non-zero register.
    function automatic logic addr_hit(input logic we, input logic [ADDR_W-1:0] wa,
                                      input logic [ADDR_W-1:0] a);
        return we && (wa == a) && (a != '0);
    endfunction

    // M beats W; a load still in M has no data yet, so it falls through to W.
    function automatic fwd_sel_e fwd_pick(input logic [ADDR_W-1:0] a,
                                          input logic we_m, input logic [ADDR_W-1:0] wa_m,
                                          input logic load_m,
                                          input logic we_w, input logic [ADDR_W-1:0] wa_w);
        if (addr_hit(we_m, wa_m, a) && !load_m) return FWD_M;
        if (addr_hit(we_w, wa_w, a))            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-stage observations and hazard controls.
// master = pipeline datapath, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [ADDR_W-1:0] A1D, A2D, A1E, A2E;
    logic [ADDR_W-1:0] WAE, WAM, WAW;
    logic              A1UseD, A2UseD, BranchD;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              MemtoRegE, MemtoRegM;
    logic              MDStartE, MDTypeE, MDUseD;

    logic              StallF, StallD, FlushE;
    logic [1:0]        FwdA1D, FwdA2D, FwdA1E, FwdA2E;
    logic              MDBusy;

    modport master (
        output A1D, A2D, A1E, A2E, WAE, WAM, WAW,
               A1UseD, A2UseD, BranchD,
               RegWriteE, RegWriteM, RegWriteW,
               MemtoRegE, MemtoRegM,
               MDStartE, MDTypeE, MDUseD,
        input  StallF, StallD, FlushE,
               FwdA1D, FwdA2D, FwdA1E, FwdA2E, MDBusy
    );

    modport slave (
        input  A1D, A2D, A1E, A2E, WAE, WAM, WAW,
               A1UseD, A2UseD, BranchD,
               RegWriteE, RegWriteM, RegWriteW,
               MemtoRegE, MemtoRegM,
               MDStartE, MDTypeE, MDUseD,
        output StallF, StallD, FlushE,
               FwdA1D, FwdA2D, FwdA1E, FwdA2E, MDBusy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Multi-cycle mult/div busy tracker: loads the unit latency on start,
// counts down to zero; busy while non-zero.
module md_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] count;

    // A start arriving while busy is dropped; the MD stall prevents it upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start && (count == '0)) begin
            count <= div ? DIV_CNT : MULT_CNT;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/scheduling controller for the five-stage pipeline: forwarding selects,
// load-use/branch stalls and (with `define MDU_EN) the mult/div busy stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    logic e_hit_a1, e_hit_a2, m_hit_a1, m_hit_a2;
    logic load_stall, branch_stall, md_stall, stall;
    logic md_busy;

    assign e_hit_a1 = addr_hit(hz.RegWriteE, hz.WAE, hz.A1D);
    assign e_hit_a2 = addr_hit(hz.RegWriteE, hz.WAE, hz.A2D);
    assign m_hit_a1 = addr_hit(hz.RegWriteM, hz.WAM, hz.A1D);
    assign m_hit_a2 = addr_hit(hz.RegWriteM, hz.WAM, hz.A2D);

    assign load_stall = hz.MemtoRegE &&
                        ((hz.A1UseD && e_hit_a1) || (hz.A2UseD && e_hit_a2));

    // Branches compare in D, so an ALU result in E or a load in M is too late.
    assign branch_stall = hz.BranchD &&
                          (e_hit_a1 || e_hit_a2 ||
                           (hz.MemtoRegM && (m_hit_a1 || m_hit_a2)));

`ifdef MDU_EN
    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk   (clk),
        .reset (reset),
        .start (hz.MDStartE),
        .div   (hz.MDTypeE),
        .busy  (md_busy)
    );

    assign md_stall = hz.MDUseD && (hz.MDStartE || md_busy);
`else
    logic unused_md;

    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
    assign unused_md = &{1'b0, clk, hz.MDStartE, hz.MDTypeE, hz.MDUseD,
                         MULT_LAT[0], DIV_LAT[0]};
`endif

    assign stall     = load_stall || branch_stall || md_stall;
    assign hz.MDBusy = md_busy;

    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FwdA1D = FWD_RF;
        hz.FwdA2D = FWD_RF;
        hz.FwdA1E = FWD_RF;
        hz.FwdA2E = FWD_RF;
        if (!reset) begin
            hz.StallF = stall;
            hz.StallD = stall;
            hz.FlushE = stall;
            hz.FwdA1D = fwd_pick(hz.A1D, hz.RegWriteM, hz.WAM, hz.MemtoRegM,
                                 hz.RegWriteW, hz.WAW);
            hz.FwdA2D = fwd_pick(hz.A2D, hz.RegWriteM, hz.WAM, hz.MemtoRegM,
                                 hz.RegWriteW, hz.WAW);
            hz.FwdA1E = fwd_pick(hz.A1E, hz.RegWriteM, hz.WAM, hz.MemtoRegM,
                                 hz.RegWriteW, hz.WAW);
            hz.FwdA2E = fwd_pick(hz.A2E, hz.RegWriteM, hz.WAM, hz.MemtoRegM,
                                 hz.RegWriteW, hz.WAW);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-indexed reference model;
// honours `define MDU_EN the same way the design does.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned MULT_TB = 5;
    localparam int unsigned DIV_TB  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MULT_LAT (MULT_TB),
        .DIV_LAT  (DIV_TB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    // Model of the mult/div unit: busy over the inclusive cycle window [busy_from, busy_last].
    int busy_from = 0;
    int busy_last = -1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit model_busy();
`ifdef MDU_EN
        return (cyc >= busy_from) && (cyc <= busy_last);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit writes(input logic we, input logic [4:0] wa, input logic [4:0] a);
        return we && (wa == a) && (a != 5'd0);
    endfunction

    function automatic int fwd_exp(input logic [4:0] a);
        if (writes(hz.RegWriteM, hz.WAM, a) && !hz.MemtoRegM) return 1;
        if (writes(hz.RegWriteW, hz.WAW, a)) return 2;
        return 0;
    endfunction

    task automatic clr_inputs();
        hz.A1D = '0; hz.A2D = '0; hz.A1E = '0; hz.A2E = '0;
        hz.WAE = '0; hz.WAM = '0; hz.WAW = '0;
        hz.A1UseD = 1'b0; hz.A2UseD = 1'b0; hz.BranchD = 1'b0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
        hz.MDStartE = 1'b0; hz.MDTypeE = 1'b0; hz.MDUseD = 1'b0;
    endtask

    // Called #1 after a rising edge with inputs set; checks mid-cycle, advances one cycle.
    task automatic run_cycle();
        bit busy, st, e1, e2;
        int f1d, f2d, f1e, f2e;
        #4;
        busy = model_busy();
        e1 = writes(hz.RegWriteE, hz.WAE, hz.A1D);
        e2 = writes(hz.RegWriteE, hz.WAE, hz.A2D);
        st = (hz.MemtoRegE && ((hz.A1UseD && e1) || (hz.A2UseD && e2))) ||
             (hz.BranchD && (e1 || e2 || (hz.MemtoRegM &&
                 (writes(hz.RegWriteM, hz.WAM, hz.A1D) ||
                  writes(hz.RegWriteM, hz.WAM, hz.A2D)))));
`ifdef MDU_EN
        st = st || (hz.MDUseD && (hz.MDStartE || busy));
`endif
        f1d = fwd_exp(hz.A1D); f2d = fwd_exp(hz.A2D);
        f1e = fwd_exp(hz.A1E); f2e = fwd_exp(hz.A2E);
        if (reset) begin
            st = 1'b0; f1d = 0; f2d = 0; f1e = 0; f2e = 0;
        end
        check_eq("StallF", int'(hz.StallF), int'(st));
        check_eq("StallD", int'(hz.StallD), int'(st));
        check_eq("FlushE", int'(hz.FlushE), int'(st));
        check_eq("FwdA1D", int'(hz.FwdA1D), f1d);
        check_eq("FwdA2D", int'(hz.FwdA2D), f2d);
        check_eq("FwdA1E", int'(hz.FwdA1E), f1e);
        check_eq("FwdA2E", int'(hz.FwdA2E), f2e);
        if (cyc > 0) check_eq("MDBusy", int'(hz.MDBusy), int'(busy));
`ifdef MDU_EN
        if (reset) begin
            if (busy_last > cyc) busy_last = cyc;
        end else if (hz.MDStartE && !busy) begin
            busy_from = cyc + 1;
            busy_last = cyc + int'(hz.MDTypeE ? DIV_TB : MULT_TB);
        end
`endif
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rand_inputs();
        hz.A1D = 5'($urandom_range(0, 3)); hz.A2D = 5'($urandom_range(0, 3));
        hz.A1E = 5'($urandom_range(0, 3)); hz.A2E = 5'($urandom_range(0, 3));
        hz.WAE = 5'($urandom_range(0, 3)); hz.WAM = 5'($urandom_range(0, 3));
        hz.WAW = 5'($urandom_range(0, 3));
        hz.A1UseD    = 1'($urandom_range(0, 1)); hz.A2UseD    = 1'($urandom_range(0, 1));
        hz.BranchD   = 1'($urandom_range(0, 1));
        hz.RegWriteE = 1'($urandom_range(0, 1)); hz.RegWriteM = 1'($urandom_range(0, 1));
        hz.RegWriteW = 1'($urandom_range(0, 1));
        hz.MemtoRegE = 1'($urandom_range(0, 1)); hz.MemtoRegM = 1'($urandom_range(0, 1));
        hz.MDTypeE   = 1'($urandom_range(0, 1));
        hz.MDUseD    = ($urandom_range(0, 2) == 0);
        // The pipeline never issues a mult/div into a busy unit.
        hz.MDStartE  = !model_busy() && ($urandom_range(0, 5) == 0);
        reset        = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        clr_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        // Reset: outputs held at 0 even with hazards present.
        hz.RegWriteM = 1'b1; hz.WAM = 5'd3; hz.A1E = 5'd3; hz.A1D = 5'd3;
        hz.RegWriteE = 1'b1; hz.WAE = 5'd3; hz.BranchD = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;

        // Load-use, then the load moving through M and W.
        clr_inputs();
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WAE = 5'd8;
        hz.A1D = 5'd8; hz.A1UseD = 1'b1;
        run_cycle();
        clr_inputs();
        hz.MemtoRegM = 1'b1; hz.RegWriteM = 1'b1; hz.WAM = 5'd8; hz.A1E = 5'd8;
        run_cycle();
        clr_inputs();
        hz.RegWriteW = 1'b1; hz.WAW = 5'd8; hz.A1E = 5'd8;
        run_cycle();

        // Forward priority M over W, then W only, then r0.
        clr_inputs();
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.WAM = 5'd9; hz.WAW = 5'd9; hz.A2E = 5'd9;
        run_cycle();
        hz.RegWriteM = 1'b0;
        run_cycle();
        hz.A2E = 5'd0; hz.WAW = 5'd0;
        run_cycle();

        // Branch on an E result, then forwarded from M.
        clr_inputs();
        hz.BranchD = 1'b1; hz.A1D = 5'd5; hz.RegWriteE = 1'b1; hz.WAE = 5'd5;
        run_cycle();
        clr_inputs();
        hz.BranchD = 1'b1; hz.A1D = 5'd5; hz.RegWriteM = 1'b1; hz.WAM = 5'd5;
        run_cycle();

        // Divide with a dependent MD instruction waiting in D.
        clr_inputs();
        hz.MDStartE = 1'b1; hz.MDTypeE = 1'b1; hz.MDUseD = 1'b1;
        run_cycle();
        hz.MDStartE = 1'b0;
        for (int unsigned i = 0; i < 12; i++) run_cycle();

        // Multiply interrupted by reset at t+3.
        clr_inputs();
        hz.MDStartE = 1'b1;
        run_cycle();
        hz.MDStartE = 1'b0; hz.MDUseD = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int unsigned i = 0; i < 3; i++) run_cycle();

        for (int unsigned i = 0; i < 600; i++) begin
            rand_inputs();
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and scheduling controller for the five-stage pipeline. Watches register addresses and write controls in the D, E, M and W stages and drives the stall and flush controls of the F/D and D/E pipeline registers. Generates forwarding selects for the D-stage comparator and the E-stage ALU. Also tracks a multi-cycle multiply/divide unit with a busy counter, so dependent instructions are held in D until HI/LO is ready.

## Interface
Parameters:
- MULT_LAT, 5, busy cycles after a multiply starts
- DIV_LAT, 10, busy cycles after a divide starts; must be ≤ 15 (4-bit counter)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- A1D, A2D  in  5 each  rs/rt addresses of the instruction in D
- A1UseD, A2UseD  in  1 each  D instruction reads rs/rt
- BranchD  in  1  D instruction compares operands in D
- A1E, A2E  in  5 each  rs/rt addresses in E
- WAE, WAM, WAW  in  5 each  destination addresses in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes the register file
- MemtoRegE, MemtoRegM  in  1 each  stage holds a load
- MDStartE  in  1  mult/div issues from E this cycle
- MDTypeE  in  1  0 = multiply, 1 = divide
- MDUseD  in  1  D instruction is any mult/div/mfhi/mflo/mthi/mtlo
- StallF, StallD  out  1 each  hold PC and the F/D register
- FlushE  out  1  clear the D/E register (insert bubble)
- FwdA1D, FwdA2D  out  2 each  D operand source: 0 regfile, 1 M result, 2 W result
- FwdA1E, FwdA2E  out  2 each  E operand source, same encoding
- MDBusy  out  1  mult/div counter non-zero

## Operation
- A forward match on address A requires RegWriteX = 1, WAX == A and A ≠ 0. M has priority over W.
- E forwarding: FwdA1E = 1 on an M match for A1E that is not a load (MemtoRegM = 0); else 2 on a W match for A1E; else 0. A2E is handled the same way.
- D forwarding: same rule applied to A1D/A2D.
- Load-use stall: MemtoRegE and an E match on (A1D & A1UseD) or (A2D & A2UseD).
- Branch stall: BranchD and either
  - an E match on A1D or A2D, or
  - MemtoRegM and an M match on A1D or A2D.
- MD stall (MDU_EN only): MDUseD and (MDStartE or MDBusy).
- stall = OR of the terms above. StallF = StallD = FlushE = stall.
- Busy counter, 4 bits:
  - reset → 0.
  - MDStartE with counter = 0 → load MULT_LAT or DIV_LAT, selected by MDTypeE.
  - Otherwise, if non-zero → decrement.
  - MDBusy = (counter ≠ 0).
- MDStartE while busy cannot occur, because the MD stall holds it in D. The bench asserts this and the counter ignores it.
- While reset = 1, all stall, flush and forward outputs are forced to 0.

## Timing
- Forward and stall outputs are combinational from the current-cycle inputs; zero latency.
- MDStartE in cycle t gives MDBusy = 1 in cycles t+1 .. t+LAT, and 0 in t+LAT+1.
- A dependent MDUseD in cycle t is stalled; it is released in the first cycle with MDBusy = 0.
- Reset and MDStartE in the same cycle: reset wins, counter = 0.
- Reset mid-count: counter clears at the next edge.
- Reset values: counter 0, MDBusy 0, all other outputs 0.

## Configuration
- MDU_EN defined: busy counter and MD stall term are present.
- MDU_EN undefined:
  - counter is removed and MDBusy is tied to 0;
  - MDStartE, MDTypeE and MDUseD are ignored;
  - MULT_LAT and DIV_LAT are unused.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - FWD_RF = 2'd0, FWD_M = 2'd1, FWD_W = 2'd2
  - default MULT_LAT and DIV_LAT
  - counter width 4
- One sub-module, md_busy_counter: counter, load/decrement logic and MDBusy, instantiated under MDU_EN.
- Forward and stall logic stays flat in pipe_hazard_ctrl.

## Test plan
- Load-use: MemtoRegE = 1, RegWriteE = 1, WAE = 8, A1D = 8, A1UseD = 1 → StallF = StallD = FlushE = 1. Next cycle, with the load now in M, there is no stall and FwdA1E = 2 once the load reaches W.
- Forward priority: WAM = WAW = 9, both RegWrite = 1, A2E = 9 → FwdA2E = 1. With RegWriteM = 0 → FwdA2E = 2. With A2E = 0 → FwdA2E = 0.
- Branch: BranchD = 1, A1D = 5, RegWriteE = 1, WAE = 5 → stall. Next cycle, with MemtoRegM = 0 and WAM = 5 → no stall, FwdA1D = 1.
- Divide: MDStartE = 1, MDTypeE = 1 at t → MDBusy high t+1..t+10. MDUseD = 1 throughout → stall through t+10, released at t+11.
- Reset at t+3 of a multiply → MDBusy = 0 at t+4, all outputs 0 during reset. Repeat with MDU_EN undefined → MDBusy always 0, no MD stall.
